// File: rtl/d_latch_neg_level.sv
// Negative-level-sensitive D latch: transparent while en_in is low, holding while high.
// A clk-domain monitor reports the synchronized latch state and counts latch-close events.
module d_latch_neg_level #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 en_in,
  output logic [WIDTH-1:0]     q_out,
  output logic                 open_o,
  output logic                 close_pulse_o,
  output logic [CNT_WIDTH-1:0] close_count_o
);

  logic [WIDTH-1:0]     q_lat;
  logic                 en_s1;
  logic                 en_s2;
  logic                 en_prev;
  logic                 open_q;
  logic                 pulse_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 close_det;

  // Data path: one storage element per bit, all sharing en_in; reset dominates.
  always_latch begin
    if (!rst_n) begin
      q_lat <= '0;
    end else if (!en_in) begin
      q_lat <= d_in;
    end
  end

  assign q_out = q_lat;

  // Synchronizer and edge history reset to "closed" so reset release cannot fake a close.
  assign close_det = en_s2 & ~en_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s1   <= 1'b1;
      en_s2   <= 1'b1;
      en_prev <= 1'b1;
      open_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      en_s1   <= en_in;
      en_s2   <= en_s1;
      en_prev <= en_s2;
      open_q  <= ~en_s2;
      pulse_q <= close_det;
      if (close_det && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign open_o        = open_q;
  assign close_pulse_o = pulse_q;
  assign close_count_o = cnt_q;

endmodule

// File: tb/tb_d_latch_neg_level.sv
// Bench for d_latch_neg_level: randomized latch stimulus scored against a behavioural
// latch model, plus close-event and open-state tracking on the clk side.
module tb_d_latch_neg_level;

  localparam int W  = 4;
  localparam int CW = 3;
  localparam int MAX_CYC = 4096;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  d_in;
  logic          en_in;
  logic [W-1:0]  q_out;
  logic          open_o;
  logic          close_pulse_o;
  logic [CW-1:0] close_count_o;

  d_latch_neg_level #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .d_in          (d_in),
    .en_in         (en_in),
    .q_out         (q_out),
    .open_o        (open_o),
    .close_pulse_o (close_pulse_o),
    .close_count_o (close_count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] cnt_q[$];
  event          chk_ev;

  logic [W-1:0]  model_q = '0;
  int            n_closes = 0;

  logic          en_at[MAX_CYC];
  logic          rst_at[MAX_CYC];
  int            cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: one input update per clk, placed just after the falling edge
  task automatic drive(input logic r, input logic e, input logic [W-1:0] d);
    logic rising;
    @(negedge clk);
    #1;
    rising = r && rst_n && e && !en_in;
    rst_n = r;
    en_in = e;
    d_in  = d;
    if (!r) begin
      model_q  = '0;
      n_closes = 0;
    end else if (!e) begin
      model_q = d;
    end
    if (rising) begin
      n_closes++;
      cnt_q.push_back((n_closes > 7) ? CW'(7) : CW'(n_closes));
    end
    exp_q.push_back(model_q);
    ->chk_ev;
  endtask

  // record what the monitor side saw at each rising edge
  always @(posedge clk) begin
    if (cyc < MAX_CYC) begin
      en_at[cyc]  = en_in;
      rst_at[cyc] = rst_n;
    end
    cyc++;
  end

  // scoreboard: latch output
  always begin
    logic [W-1:0] e;
    @(chk_ev);
    #1;
    if (exp_q.size() == 0) begin
      check("q_out_no_expect", 32'(q_out), 32'hDEAD);
    end else begin
      e = exp_q.pop_front();
      check("q_out", 32'(q_out), 32'(e));
    end
  end

  // scoreboard: close pulses carry the expected saturating count
  always @(negedge clk) begin
    if (close_pulse_o) begin
      if (cnt_q.size() == 0) begin
        check("unexpected_close_pulse", 32'(close_pulse_o), 32'd0);
      end else begin
        check("close_count_o", 32'(close_count_o), 32'(cnt_q.pop_front()));
      end
    end
  end

  // open_o reflects en_in as seen three rising edges back, cleared by any reset in that window
  always @(negedge clk) begin
    int c;
    logic exp_open;
    c = cyc - 1;
    if (c >= 2 && c < MAX_CYC) begin
      exp_open = rst_n && rst_at[c] && rst_at[c-1] && rst_at[c-2] && !en_at[c-2];
      check("open_o", 32'(open_o), 32'(exp_open));
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int hold;
    logic e;
    rst_n = 1'b0;
    en_in = 1'b0;
    d_in  = 4'hF;

    // reset dominates a transparent latch
    drive(1'b0, 1'b0, 4'hF);
    #1;
    check("reset_open", 32'(open_o), 32'd0);
    check("reset_pulse", 32'(close_pulse_o), 32'd0);
    check("reset_count", 32'(close_count_o), 32'd0);
    drive(1'b0, 1'b0, 4'h5);

    // release while transparent, then follow d_in
    drive(1'b1, 1'b0, 4'hA);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 4'($urandom_range(0, 15)));

    // hold: close with F, wiggle d_in, reopen
    drive(1'b1, 1'b0, 4'hF);
    drive(1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, (i % 2 == 0) ? 4'h0 : 4'h6);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'($urandom_range(0, 15)));

    // d_in changes together with the close: the pre-edge value is kept
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h3);
    drive(1'b1, 1'b1, 4'hC);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'($urandom_range(0, 15)));

    // randomized run, every enable level held at least three clocks
    e = 1'b1;
    hold = 4;
    for (int i = 0; i < 150; i++) begin
      if (hold >= 3 && $urandom_range(0, 2) == 0) begin
        e = ~e;
        hold = 0;
      end
      drive(1'b1, e, 4'($urandom_range(0, 15)));
      hold++;
    end
    while (hold < 3) begin
      drive(1'b1, e, 4'($urandom_range(0, 15)));
      hold++;
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 4'($urandom_range(0, 15)));
    check("saturated_count", 32'(close_count_o), 32'd7);

    // reset in the middle of a hold
    drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    #1;
    check("midreset_open", 32'(open_o), 32'd0);
    check("midreset_pulse", 32'(close_pulse_o), 32'd0);
    check("midreset_count", 32'(close_count_o), 32'd0);
    drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));

    // release while holding keeps zero until reopened
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'($urandom_range(1, 15)));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 4'($urandom_range(0, 15)));
    end
    check("restart_count", 32'(close_count_o), 32'd2);

    repeat (4) @(negedge clk);
    #3;
    check("q_queue_drained", 32'(exp_q.size()), 32'd0);
    check("close_queue_drained", 32'(cnt_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/d_latch_neg_level.md
Name: d_latch_neg_level

Overview:
- Negative-level-sensitive D latch (NLS): transparent while en_in is low, opaque/holding while en_in is high.
- Includes a clock-domain status/monitor side that reports latch state and counts latch-close events for software or debug.
- Used as a storage primitive and as a latch-behaviour reference block in gate-level/latch experiments.

Parameters:
- WIDTH, 1, data width of d_in and q_out.
- CNT_WIDTH, 8, width of the saturating close-event counter.

Ports:
- clk  input  1  system clock; used for status logic only, never gates the data path.
- rst_n  input  1  asynchronous active-low reset; one clock, async assert, active-low.
- d_in  input  WIDTH  latch data input.
- en_in  input  1  latch enable, active-low transparency (0 = transparent, 1 = hold); asynchronous to clk.
- q_out  output  WIDTH  latch output.
- open_o  output  1  registered status: 1 when the synchronized enable shows the latch transparent.
- close_pulse_o  output  1  one-clk pulse per detected latch-close (synchronized en_in 0->1).
- close_count_o  output  CNT_WIDTH  saturating count of close events since reset.

Behaviour:
Data path (level-sensitive, no clock involvement):
- rst_n=0 forces the stored value and q_out to 0 immediately, regardless of d_in or en_in. Reset dominates en_in.
- rst_n=1, en_in=0: q_out follows d_in combinationally (zero-cycle latency, transparent).
- rst_n=1, en_in=1: q_out holds the d_in value present at the en_in 0->1 transition. Later d_in changes are ignored.
- d_in changing simultaneously with en_in rising: the pre-edge d_in value is captured. Hold margin is the integrator's responsibility.
- Reset released while en_in=1: q_out stays 0 until en_in next goes low.
- Reset released while en_in=0: q_out immediately follows d_in.
- Width: bitwise per-bit latch, all bits share en_in.

Status path (clk domain):
- en_in passes through a 2-flop synchronizer (en_s1, en_s2). Both flops reset to 1 ("closed"), so no spurious event is produced at reset release.
- Register en_prev <= en_s2, reset 1.
- open_o <= ~en_s2 (registered). Resets to 0.
- close_pulse_o <= en_s2 & ~en_prev. Resets to 0. High for exactly one clk per close event.
- close_count_o increments by 1 on each close_pulse condition and saturates at all-ones (no wrap). Resets to 0.
- Status latency: en_in edge to open_o / close_pulse_o change is 3 clk rising edges (two synchronizer stages plus the output register).
- en_in pulses shorter than 2 clk periods may be missed by the status path. This is allowed; the data path still honours them.
- Reset mid-operation: all status registers clear asynchronously. The count restarts from 0.

Test Plan:
- Reset: rst_n=0, d_in=1, en_in=0 -> q_out=0, open_o=0, close_pulse_o=0, close_count_o=0.
- Transparency: rst_n=1, en_in=0, toggle d_in 0->1->0 every 6 time units -> q_out equals d_in at every sample, with no clk dependence.
- Hold: d_in=1, raise en_in to 1, toggle d_in every 6 units for 30 units -> q_out stays 1. Lower en_in to 0 -> q_out tracks d_in again.
- Free-running combined stimulus: d_in period 12, en_in period 20, both start at 0, run 300 units -> q_out matches a golden NLS model at every $monitor change. At t=10 en_in rises with d_in=1, so q_out holds 1 until t=20.
- Status: with a 1-unit-period clk, 5 en_in 0->1 edges -> exactly 5 close_pulse_o pulses and close_count_o=5. open_o lags en_in by 3 clk.
- Saturation/reset: CNT_WIDTH=2, 6 close events -> close_count_o=3. Assert rst_n mid-hold -> q_out and all status outputs go to 0 immediately.
